// File: rtl/control_fsm_pkg.sv
// control_pkg
// Shared encodings for the multicycle control unit of the 16-bit CPU:
// the 4-bit state enum (its value is exported on fsmState), opcode and
// opExt constants used by instruction decode, condition-code encodings
// and the bit positions of the flags inside the PSR.
package control_pkg;

   typedef enum logic [3:0] {
      ST_FETCH       = 4'd0,
      ST_FETCH_LATCH = 4'd1,
      ST_DECODE      = 4'd2,
      ST_ALU_R       = 4'd3,
      ST_ALU_I       = 4'd4,
      ST_CMP_R       = 4'd5,
      ST_CMP_I       = 4'd6,
      ST_WB          = 4'd7,
      ST_LOAD_ADDR   = 4'd8,
      ST_LOAD_WAIT   = 4'd9,
      ST_LOAD_SEL    = 4'd10,
      ST_STORE       = 4'd11,
      ST_BRANCH      = 4'd12,
      ST_JCOND       = 4'd13,
      ST_JAL         = 4'd14
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_MEMJ  = 4'b0100;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_NOP   = 4'b1111;

   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STORE = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_FS = 4'b1000;
   localparam logic [3:0] COND_FC = 4'b1001;
   localparam logic [3:0] COND_LO = 4'b1010;
   localparam logic [3:0] COND_HS = 4'b1011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int PSR_C = 0;
   localparam int PSR_L = 2;
   localparam int PSR_F = 5;
   localparam int PSR_Z = 6;
   localparam int PSR_N = 7;

   // Immediate-form ALU opcodes all share the ALU_I -> WB path.
   function automatic logic isImmAluOp(input logic [3:0] op);
      case (op)
         4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
         4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110: isImmAluOp = 1'b1;
         default:                                     isImmAluOp = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if
// Bundle between the control unit and the datapath/memory system.
//   instr, PSR, aluOutIsZero : datapath -> control
//   every enable/select, memWrite, addrSelect, fsmState : control -> datapath
// master is the control unit side, slave is the datapath side.
interface control_fsm_if;

   logic [15:0] instr;
   logic [7:0]  PSR;
   logic        aluOutIsZero;

   logic        pcEn;
   logic        instrWrite;
   logic        regWrite;
   logic        writeBackSelect;
   logic        dataToWriteSelect;
   logic        newAluInput;
   logic [1:0]  aluSrc1Select;
   logic [1:0]  aluSrc2Select;
   logic [1:0]  pcSrc;
   logic        memWrite;
   logic        addrSelect;
   logic [3:0]  fsmState;

   modport master (
      input  instr, PSR, aluOutIsZero,
      output pcEn, instrWrite, regWrite, writeBackSelect, dataToWriteSelect,
             newAluInput, aluSrc1Select, aluSrc2Select, pcSrc, memWrite,
             addrSelect, fsmState
   );

   modport slave (
      output instr, PSR, aluOutIsZero,
      input  pcEn, instrWrite, regWrite, writeBackSelect, dataToWriteSelect,
             newAluInput, aluSrc1Select, aluSrc2Select, pcSrc, memWrite,
             addrSelect, fsmState
   );

endinterface

// File: rtl/control_fsm_cond_eval.sv
// cond_eval
// Combinational branch/jump condition evaluator.
//   cond [3:0] : condition code from instr[11:8]
//   PSR  [7:0] : processor status flags
//   take       : 1 when the condition holds
module cond_eval
   import control_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [7:0] PSR,
   output logic       take
);

   logic flagC, flagL, flagF, flagZ, flagN;
   logic unusedPsrBits;

   assign flagC = PSR[PSR_C];
   assign flagL = PSR[PSR_L];
   assign flagF = PSR[PSR_F];
   assign flagZ = PSR[PSR_Z];
   assign flagN = PSR[PSR_N];
   assign unusedPsrBits = ^{PSR[4:3], PSR[1]};

   // One equation per condition code; NV is the only never-taken code and
   // also covers anything unexpected.
   always_comb begin
      take = 1'b0;
      case (cond)
         COND_EQ: take = flagZ;
         COND_NE: take = !flagZ;
         COND_CS: take = flagC;
         COND_CC: take = !flagC;
         COND_HI: take = flagL;
         COND_LS: take = !flagL;
         COND_GT: take = flagN;
         COND_LE: take = !flagN;
         COND_FS: take = flagF;
         COND_FC: take = !flagF;
         COND_LO: take = !flagL && !flagZ;
         COND_HS: take = flagL || flagZ;
         COND_LT: take = !flagN && !flagZ;
         COND_GE: take = flagN || flagZ;
         COND_UC: take = 1'b1;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// control_fsm
// Multicycle control unit: sequences fetch, decode, execute, memory and
// write-back and drives every datapath enable and mux select.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high, returns to FETCH
//   bus   : control_fsm_if.master -- instr/PSR in, datapath controls out,
//           plus fsmState exposing the current state encoding
module control_fsm
   import control_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   control_fsm_if.master  bus
);

   state_t state;
   state_t nextState;
   logic   condTake;
   logic   unusedInputs;

   assign unusedInputs = ^{bus.aluOutIsZero, bus.instr[3:0]};

   cond_eval condEval (
      .cond (bus.instr[11:8]),
      .PSR  (bus.PSR),
      .take (condTake)
   );

   // State register. Reset takes priority over whatever transition the
   // next-state logic wants, so an interrupted instruction is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. Only DECODE branches; every other state has a fixed
   // successor. Unknown opcodes and unknown 0100 extensions fall back to
   // FETCH so they behave as NOPs.
   always_comb begin
      nextState = ST_FETCH;
      case (state)
         ST_FETCH:       nextState = ST_FETCH_LATCH;
         ST_FETCH_LATCH: nextState = ST_DECODE;
         ST_DECODE: begin
            case (bus.instr[15:12])
               OP_RTYPE: nextState = (bus.instr[7:4] == EXT_CMP) ? ST_CMP_R : ST_ALU_R;
               OP_CMPI:  nextState = ST_CMP_I;
               OP_BCOND: nextState = ST_BRANCH;
               OP_MEMJ: begin
                  case (bus.instr[7:4])
                     EXT_LOAD:  nextState = ST_LOAD_ADDR;
                     EXT_STORE: nextState = ST_STORE;
                     EXT_JCOND: nextState = ST_JCOND;
                     EXT_JAL:   nextState = ST_JAL;
                     default:   nextState = ST_FETCH;
                  endcase
               end
               default: nextState = isImmAluOp(bus.instr[15:12]) ? ST_ALU_I : ST_FETCH;
            endcase
         end
         ST_ALU_R:     nextState = ST_WB;
         ST_ALU_I:     nextState = ST_WB;
         ST_LOAD_ADDR: nextState = ST_LOAD_WAIT;
         ST_LOAD_WAIT: nextState = ST_LOAD_SEL;
         ST_LOAD_SEL:  nextState = ST_WB;
         default:      nextState = ST_FETCH;
      endcase
   end

   // Output decode. Everything is a pure function of state except pcEn in
   // BRANCH/JCOND, which is gated by the condition evaluated against the
   // live PSR. In JAL the register file writes the already-incremented PC
   // while the PC loads B on the same edge.
   always_comb begin
      bus.pcEn              = 1'b0;
      bus.instrWrite        = 1'b0;
      bus.regWrite          = 1'b0;
      bus.writeBackSelect   = 1'b0;
      bus.dataToWriteSelect = 1'b0;
      bus.newAluInput       = 1'b0;
      bus.aluSrc1Select     = 2'b00;
      bus.aluSrc2Select     = 2'b00;
      bus.pcSrc             = 2'b00;
      bus.memWrite          = 1'b0;
      bus.addrSelect        = 1'b0;
      case (state)
         ST_FETCH_LATCH: begin
            bus.instrWrite = 1'b1;
            bus.pcEn       = 1'b1;
         end
         ST_DECODE: bus.newAluInput = 1'b1;
         ST_ALU_R, ST_CMP_R: begin
            bus.aluSrc1Select = 2'b01;
            bus.aluSrc2Select = 2'b00;
         end
         ST_ALU_I, ST_CMP_I: begin
            bus.aluSrc1Select = 2'b01;
            bus.aluSrc2Select = 2'b01;
         end
         ST_WB:        bus.regWrite = 1'b1;
         ST_LOAD_ADDR: bus.addrSelect = 1'b1;
         ST_LOAD_WAIT: bus.addrSelect = 1'b1;
         ST_LOAD_SEL:  bus.writeBackSelect = 1'b1;
         ST_STORE: begin
            bus.addrSelect = 1'b1;
            bus.memWrite   = 1'b1;
         end
         ST_BRANCH: begin
            bus.pcSrc = 2'b10;
            bus.pcEn  = condTake;
         end
         ST_JCOND: begin
            bus.pcSrc = 2'b01;
            bus.pcEn  = condTake;
         end
         ST_JAL: begin
            bus.regWrite          = 1'b1;
            bus.dataToWriteSelect = 1'b1;
            bus.pcEn              = 1'b1;
            bus.pcSrc             = 2'b01;
         end
         default: begin
         end
      endcase
   end

   assign bus.fsmState = state;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm
// Directed bench for control_fsm. Each instruction pushes its hand-written
// per-cycle output vectors into a scoreboard queue; a negedge monitor pops
// one vector per cycle and compares it with the full set of DUT outputs.
module tb_control_fsm;

   logic clk = 1'b0;
   logic reset;

   control_fsm_if bus ();

   control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcEn;
      logic       instrWrite;
      logic       regWrite;
      logic       wbSel;
      logic       dtwSel;
      logic       newAlu;
      logic [1:0] src1;
      logic [1:0] src2;
      logic [1:0] pcSrc;
      logic       memWrite;
      logic       addrSel;
   } outVec_t;

   typedef struct {
      outVec_t v;
      string   tag;
   } expItem_t;

   expItem_t expQ[$];
   outVec_t  seqQ[$];
   int checks = 0;
   int errors = 0;

   // Hand-written expected vectors, one per state.
   function automatic outVec_t base(input logic [3:0] st);
      outVec_t v;
      v = '0;
      v.st = st;
      return v;
   endfunction

   function automatic outVec_t vFetch();
      return base(4'd0);
   endfunction

   function automatic outVec_t vLatch();
      outVec_t v = base(4'd1);
      v.instrWrite = 1'b1; v.pcEn = 1'b1; v.pcSrc = 2'b00;
      return v;
   endfunction

   function automatic outVec_t vDecode();
      outVec_t v = base(4'd2);
      v.newAlu = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vAluR();
      outVec_t v = base(4'd3);
      v.src1 = 2'b01; v.src2 = 2'b00;
      return v;
   endfunction

   function automatic outVec_t vAluI();
      outVec_t v = base(4'd4);
      v.src1 = 2'b01; v.src2 = 2'b01;
      return v;
   endfunction

   function automatic outVec_t vCmpR();
      outVec_t v = base(4'd5);
      v.src1 = 2'b01; v.src2 = 2'b00;
      return v;
   endfunction

   function automatic outVec_t vCmpI();
      outVec_t v = base(4'd6);
      v.src1 = 2'b01; v.src2 = 2'b01;
      return v;
   endfunction

   function automatic outVec_t vWb();
      outVec_t v = base(4'd7);
      v.regWrite = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vLdAddr();
      outVec_t v = base(4'd8);
      v.addrSel = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vLdWait();
      outVec_t v = base(4'd9);
      v.addrSel = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vLdSel();
      outVec_t v = base(4'd10);
      v.wbSel = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vStore();
      outVec_t v = base(4'd11);
      v.addrSel = 1'b1; v.memWrite = 1'b1;
      return v;
   endfunction

   function automatic outVec_t vBranch(input logic take);
      outVec_t v = base(4'd12);
      v.pcSrc = 2'b10; v.pcEn = take;
      return v;
   endfunction

   function automatic outVec_t vJcond(input logic take);
      outVec_t v = base(4'd13);
      v.pcSrc = 2'b01; v.pcEn = take;
      return v;
   endfunction

   function automatic outVec_t vJal();
      outVec_t v = base(4'd14);
      v.regWrite = 1'b1; v.dtwSel = 1'b1; v.pcEn = 1'b1; v.pcSrc = 2'b01;
      return v;
   endfunction

   // Reference condition equations, written straight from the flag table.
   function automatic logic refTake(input logic [3:0] c, input logic [7:0] p);
      logic fc, fl, ff, fz, fn;
      fc = p[0]; fl = p[2]; ff = p[5]; fz = p[6]; fn = p[7];
      case (c)
         4'd0:  return fz;
         4'd1:  return !fz;
         4'd2:  return fc;
         4'd3:  return !fc;
         4'd4:  return fl;
         4'd5:  return !fl;
         4'd6:  return fn;
         4'd7:  return !fn;
         4'd8:  return ff;
         4'd9:  return !ff;
         4'd10: return !fl && !fz;
         4'd11: return fl || fz;
         4'd12: return !fn && !fz;
         4'd13: return fn || fz;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Drives one instruction: queues every vector in seqQ, then lets the
   // given number of cycles elapse. Called just after a rising edge.
   task automatic applyStimulus(input logic [15:0] ins, input logic [7:0] psr,
                                input string tag, input int waitCycles);
      bus.instr = ins;
      bus.PSR   = psr;
      foreach (seqQ[i]) expQ.push_back('{seqQ[i], $sformatf("%s.c%0d", tag, i)});
      seqQ.delete();
      repeat (waitCycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input expItem_t item);
      outVec_t act;
      act.st       = bus.fsmState;
      act.pcEn     = bus.pcEn;
      act.instrWrite = bus.instrWrite;
      act.regWrite = bus.regWrite;
      act.wbSel    = bus.writeBackSelect;
      act.dtwSel   = bus.dataToWriteSelect;
      act.newAlu   = bus.newAluInput;
      act.src1     = bus.aluSrc1Select;
      act.src2     = bus.aluSrc2Select;
      act.pcSrc    = bus.pcSrc;
      act.memWrite = bus.memWrite;
      act.addrSel  = bus.addrSelect;
      checks++;
      if (act !== item.v) begin
         errors++;
         $display("[TB] FAIL %s got %b required %b", item.tag, act, item.v);
      end
   endtask

   // Monitor: one expected vector per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() != 0) checkOutput(expQ.pop_front());
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [7:0] psrList [3];
      logic [15:0] ins;
      psrList[0] = 8'h40;
      psrList[1] = 8'h85;
      psrList[2] = 8'h24;

      reset = 1'b1;
      bus.instr = 16'h0000;
      bus.PSR = 8'h00;
      bus.aluOutIsZero = 1'b0;

      @(posedge clk); #1;
      expQ.push_back('{vFetch(), "reset1"});
      @(posedge clk); #1;
      reset = 1'b0;

      seqQ = {vFetch(), vLatch(), vDecode(), vAluR(), vWb()};
      applyStimulus(16'h0152, 8'h00, "addR", 5);
      seqQ = {vFetch(), vLatch(), vDecode(), vCmpR()};
      applyStimulus(16'h0BB2, 8'h00, "cmpR", 4);
      seqQ = {vFetch(), vLatch(), vDecode(), vAluI(), vWb()};
      applyStimulus(16'h5103, 8'h00, "addI", 5);
      seqQ = {vFetch(), vLatch(), vDecode(), vCmpI()};
      applyStimulus(16'hB105, 8'h00, "cmpI", 4);
      seqQ = {vFetch(), vLatch(), vDecode(), vLdAddr(), vLdWait(), vLdSel(), vWb()};
      applyStimulus(16'h4102, 8'h00, "load", 7);
      seqQ = {vFetch(), vLatch(), vDecode(), vStore()};
      applyStimulus(16'h4142, 8'h00, "store", 4);
      seqQ = {vFetch(), vLatch(), vDecode(), vBranch(1'b1)};
      applyStimulus(16'hC005, 8'h40, "beqTaken", 4);
      seqQ = {vFetch(), vLatch(), vDecode(), vBranch(1'b0)};
      applyStimulus(16'hC005, 8'h00, "beqNot", 4);
      seqQ = {vFetch(), vLatch(), vDecode(), vJal()};
      applyStimulus(16'h4E83, 8'h00, "jal", 4);
      seqQ = {vFetch(), vLatch(), vDecode()};
      applyStimulus(16'hF000, 8'h00, "nop", 3);
      seqQ = {vFetch(), vLatch(), vDecode()};
      applyStimulus(16'h41F0, 8'h00, "badExt", 3);

      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 16; c++) begin
            ins = {4'h4, 4'(c), 4'hC, 4'h3};
            seqQ = {vFetch(), vLatch(), vDecode(), vJcond(refTake(4'(c), psrList[p]))};
            applyStimulus(ins, psrList[p], $sformatf("jcond%0d_psr%h", c, psrList[p]), 4);
         end
      end

      seqQ = {vFetch(), vLatch(), vDecode(), vBranch(1'b1)};
      applyStimulus(16'hCE05, 8'h00, "buc", 4);

      seqQ = {vFetch(), vLatch(), vDecode(), vLdAddr(), vLdWait()};
      applyStimulus(16'h4102, 8'h00, "loadAbort", 4);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      seqQ = {vFetch(), vLatch(), vDecode(), vAluR(), vWb()};
      applyStimulus(16'h0152, 8'h00, "addAfterReset", 5);

      @(negedge clk); #1;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard leftover got %0d required 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
